// File: rtl/data_mem_arb_pkg.sv
// Shared types, constants and the round-robin helper for the data-memory arbiter.
package data_mem_arb_pkg;

   localparam int MAX_REQ    = 4;   // largest supported requester count
   localparam int IDX_W      = 2;   // enough bits to index MAX_REQ requesters
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // First asserted index at or after ptr, wrapping modulo num_req.
   // Walking the offsets from largest to smallest lets the closest one win.
   // Returns ptr unchanged when nothing is valid.
   function automatic logic [IDX_W-1:0] next_rr(
      input logic [IDX_W-1:0]   ptr,
      input logic [MAX_REQ-1:0] valid,
      input int                 num_req
   );
      logic [IDX_W-1:0] grant;
      logic [IDX_W-1:0] idx;
      grant = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < num_req) begin
            idx = IDX_W'((int'(ptr) + k) % num_req);
            if (valid[idx]) grant = idx;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Combinational round-robin selector: request vector + pointer -> grant index.
module rr_picker
   import data_mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               any
);

   logic [MAX_REQ-1:0] valid_pad;

   // Pad the request vector to the helper's fixed width and pick a winner.
   always_comb begin
      valid_pad                = '0;
      valid_pad[NUM_REQ-1:0]   = valid;
      grant                    = next_rr(ptr, valid_pad, NUM_REQ);
      any                      = |valid;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one LC3 data-memory port between NUM_REQ
// requesters. One access at a time: accept, drive memory, wait for
// complete_data (or a watchdog timeout), then pulse the response.
// Every output is a register; nothing flows combinationally from inputs.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         req_rd,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic [ADDR_W-1:0]          Data_addr,
   output logic [DATA_W-1:0]          Data_din,
   output logic                       Data_rd,
   input  logic [DATA_W-1:0]          Data_dout,
   input  logic                       complete_data,
   output logic                       busy,
   output logic [7:0]                 err_count
);

   // Watchdog only needs to reach TIMEOUT-1 before ACCESS is left.
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
   logic [IDX_W-1:0]    cur_idx, cur_idx_d;
   logic [WD_W-1:0]     watchdog, watchdog_d;
   logic [IDX_W-1:0]    grant;
   logic                any_req;
   logic [NUM_REQ-1:0]  grant_oh;
   logic                timeout_hit;

   logic [NUM_REQ-1:0]  req_ready_d, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_d, Data_din_d;
   logic                rsp_err_d, Data_rd_d, busy_d;
   logic [ADDR_W-1:0]   Data_addr_d;
   logic [7:0]          err_count_d;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .any   (any_req)
   );

   assign grant_oh    = NUM_REQ'(1) << grant;
   assign timeout_hit = (watchdog == WD_W'(TIMEOUT - 1));

   // State register; reset wins over everything, including a live access.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decision; completion is checked before the timeout so a
   // same-cycle completion is never reported as an error.
   always_comb begin
      // NOTE: assigning a default first keeps this purely combinational;
      // a path that leaves state_nxt unassigned would infer a latch.
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (complete_data || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and internal bookkeeping.
   always_comb begin
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      Data_addr_d = Data_addr;
      Data_din_d  = Data_din;
      Data_rd_d   = Data_rd;
      err_count_d = err_count;
      rr_ptr_d    = rr_ptr;
      cur_idx_d   = cur_idx;
      watchdog_d  = watchdog;
      busy_d      = (state_nxt != IDLE);
      unique case (state)
         IDLE: begin
            if (any_req) begin
               req_ready_d = grant_oh;
               Data_addr_d = req_addr[int'(grant)*ADDR_W +: ADDR_W];
               Data_din_d  = req_wdata[int'(grant)*DATA_W +: DATA_W];
               Data_rd_d   = |(req_rd & grant_oh);
               cur_idx_d   = grant;
               watchdog_d  = '0;
            end else begin
               Data_rd_d   = 1'b1;
            end
         end
         ACCESS: begin
            watchdog_d = watchdog + WD_W'(1);
            if (complete_data) begin
               if (Data_rd) rsp_rdata_d = Data_dout;
               rsp_err_d = 1'b0;
               Data_rd_d = 1'b1;
            end else if (timeout_hit) begin
               rsp_err_d   = 1'b1;
               err_count_d = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
               Data_rd_d   = 1'b1;
            end
         end
         RESP: begin
            rsp_valid_d = NUM_REQ'(1) << cur_idx;
            rr_ptr_d    = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);
         end
         default: ;
      endcase
   end

   // Output and bookkeeping registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         Data_addr <= '0;
         Data_din  <= '0;
         Data_rd   <= 1'b1;
         busy      <= 1'b0;
         err_count <= '0;
         rr_ptr    <= '0;
         cur_idx   <= '0;
         watchdog  <= '0;
      end else begin
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         Data_addr <= Data_addr_d;
         Data_din  <= Data_din_d;
         Data_rd   <= Data_rd_d;
         busy      <= busy_d;
         err_count <= err_count_d;
         rr_ptr    <= rr_ptr_d;
         cur_idx   <= cur_idx_d;
         watchdog  <= watchdog_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter (2 requesters, 16-bit, TIMEOUT 16).
// Inputs are driven and outputs sampled on the falling edge. Cycle 0 of an
// access is the cycle in which req_ready is seen high.
module tb_data_mem_arbiter;

   localparam int N   = 2;
   localparam int TO  = 16;

   logic           clock;
   logic           reset;
   logic [N-1:0]   req_valid, req_ready, req_rd, rsp_valid;
   logic [N*16-1:0] req_addr, req_wdata;
   logic [15:0]    rsp_rdata, Data_addr, Data_din, Data_dout;
   logic           rsp_err, Data_rd, complete_data, busy;
   logic [7:0]     err_count;

   int n_checks = 0;
   int n_err    = 0;

   data_mem_arbiter #(.NUM_REQ(N), .ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
      .Data_dout(Data_dout), .complete_data(complete_data),
      .busy(busy), .err_count(err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL sim_timeout: simulation did not finish, required finish before 400000");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; complete_data = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   // One access. exp_g is the requester the bench expects to win. Returns what
   // was observed at the response so the caller can compare with its own
   // expectation. delay = ACCESS cycle in which complete_data is driven.
   task automatic run_access(
      input  logic [N-1:0]    mask,
      input  logic [N-1:0]    rd_v,
      input  logic [N*16-1:0] addr_v,
      input  logic [N*16-1:0] wdata_v,
      input  int              delay,
      input  logic [15:0]     dout,
      input  int              exp_g,
      output int              lat,
      output logic [N-1:0]    rv,
      output logic            err,
      output logic [15:0]     rdata,
      output logic [7:0]      cnt
   );
      bit got = 0;
      lat = -1; rv = '0; err = 1'b0; rdata = '0; cnt = '0;
      req_valid = mask; req_rd = rd_v; req_addr = addr_v; req_wdata = wdata_v;
      for (int w = 0; w < 8 && !got; w++) begin
         @(negedge clock);
         if (req_ready != '0) got = 1;
      end
      check("accept_seen", 64'(got), 64'd1);
      req_valid = '0;
      if (!got) return;
      check("req_ready_onehot", 64'(req_ready), 64'(N'(1) << exp_g));
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clock);
         if (rsp_valid != '0) begin
            lat = c; rv = rsp_valid; err = rsp_err; rdata = rsp_rdata; cnt = err_count;
            check("busy_at_rsp", 64'(busy), 64'd0);
            break;
         end
         if (c <= delay && c < TO)
            check("mem_port_stable", {29'd0, busy, Data_rd, Data_addr, Data_din},
                  {29'd0, 1'b1, rd_v[exp_g], addr_v[exp_g*16 +: 16], wdata_v[exp_g*16 +: 16]});
         complete_data = (c == delay);
         Data_dout     = (c == delay) ? dout : 16'($urandom);
      end
      complete_data = 1'b0;
      check("rsp_seen", 64'(lat >= 0), 64'd1);
   endtask

   typedef struct {
      logic [N-1:0] mask;
      logic         rd;
      logic [15:0]  addr;
      logic [15:0]  wdata;
      int           delay;
      logic [15:0]  dout;
      int           exp_g;
      int           exp_lat;
      logic         exp_err;
      logic [15:0]  exp_rdata;
      logic [7:0]   exp_cnt;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [N-1:0]    rd_v, rv;
      logic [N*16-1:0] addr_v, wdata_v;
      int              lat, g;
      logic            err;
      logic [15:0]     rdata;
      logic [7:0]      cnt;
      logic [N-1:0]    grants[$];
      logic [N-1:0]    rsps[$];
      int              m_rr;
      logic [7:0]      m_cnt;
      logic [15:0]     m_rdata;
      bit              got;

      // Directed vectors, applied in order from a fresh reset (pointer 0).
      vecs[0] = '{2'b01, 1'b1, 16'h3000, 16'h0000,  3, 16'hBEEF, 0,  5, 1'b0, 16'hBEEF, 8'd0}; // single read
      vecs[1] = '{2'b10, 1'b0, 16'h4010, 16'h1234,  0, 16'hAAAA, 1,  2, 1'b0, 16'hBEEF, 8'd0}; // write keeps rdata
      vecs[2] = '{2'b01, 1'b1, 16'h0055, 16'h9999, 99, 16'h0000, 0, 17, 1'b1, 16'hBEEF, 8'd1}; // timeout
      vecs[3] = '{2'b10, 1'b1, 16'h1111, 16'h0000,  1, 16'h5A5A, 1,  3, 1'b0, 16'h5A5A, 8'd1}; // serviced after timeout
      vecs[4] = '{2'b01, 1'b1, 16'h2222, 16'h0000, 15, 16'hC0DE, 0, 17, 1'b0, 16'hC0DE, 8'd1}; // completion on last watchdog cycle
      vecs[5] = '{2'b11, 1'b0, 16'h7777, 16'h0F0F,  2, 16'h0000, 1,  4, 1'b0, 16'hC0DE, 8'd1}; // pointer favours 1

      reset = 1'b0; req_valid = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
      Data_dout = '0; complete_data = 1'b0;

      // Reset state.
      do_reset();
      check("reset_state",
            {req_ready, rsp_valid, rsp_err, busy, rsp_rdata, Data_addr, Data_din, Data_rd, err_count},
            {2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 8'd0});

      // Contention: both requesters held high, completion always present.
      req_valid = 2'b11; req_rd = 2'b00; req_addr = {16'h0A01, 16'h0A00};
      req_wdata = {16'h1111, 16'h0000}; complete_data = 1'b1;
      for (int c = 0; c < 40 && rsps.size() < 4; c++) begin
         @(negedge clock);
         if (req_ready != '0) grants.push_back(req_ready);
         if (rsp_valid != '0) rsps.push_back(rsp_valid);
      end
      req_valid = '0; complete_data = 1'b0;
      check("contention_rsp_count", 64'(rsps.size()), 64'd4);
      check("contention_grant_count", 64'(grants.size() >= 4), 64'd1);
      for (int k = 0; k < 4 && k < rsps.size() && k < grants.size(); k++) begin
         check("contention_grant_order", 64'(grants[k]), 64'(N'(1) << (k % 2)));
         check("contention_rsp_match", 64'(rsps[k]), 64'(grants[k]));
      end

      // Table-driven directed vectors.
      do_reset();
      foreach (vecs[i]) begin
         for (int r = 0; r < N; r++) begin
            rd_v[r]              = (r == vecs[i].exp_g) ? vecs[i].rd    : ~vecs[i].rd;
            addr_v[r*16 +: 16]   = (r == vecs[i].exp_g) ? vecs[i].addr  : ~vecs[i].addr;
            wdata_v[r*16 +: 16]  = (r == vecs[i].exp_g) ? vecs[i].wdata : ~vecs[i].wdata;
         end
         run_access(vecs[i].mask, rd_v, addr_v, wdata_v, vecs[i].delay, vecs[i].dout,
                    vecs[i].exp_g, lat, rv, err, rdata, cnt);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("vec%0d_rsp_valid", i), 64'(rv), 64'(N'(1) << vecs[i].exp_g));
         check($sformatf("vec%0d_rsp_err", i), 64'(err), 64'(vecs[i].exp_err));
         check($sformatf("vec%0d_rsp_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
         check($sformatf("vec%0d_err_count", i), 64'(cnt), 64'(vecs[i].exp_cnt));
      end

      // Reset in the middle of an access, then a late completion.
      req_valid = 2'b10; req_rd = 2'b11; req_addr = {16'h6000, 16'h6001};
      got = 0;
      for (int w = 0; w < 8 && !got; w++) begin
         @(negedge clock);
         if (req_ready != '0) got = 1;
      end
      check("midreset_accept", 64'(got), 64'd1);
      req_valid = '0;
      @(negedge clock);
      check("midreset_in_access", 64'(busy), 64'd1);
      reset = 1'b0;
      @(negedge clock);
      check("midreset_idle", {req_ready, rsp_valid, busy, Data_rd, Data_addr, err_count},
            {2'b00, 2'b00, 1'b0, 1'b1, 16'h0, 8'd0});
      reset = 1'b1; complete_data = 1'b1; Data_dout = 16'hDEAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("late_complete_ignored", {rsp_valid, busy, rsp_rdata}, {2'b00, 1'b0, 16'h0});
      end
      complete_data = 1'b0;

      // Randomised accesses against a reference model of the arbitration rules.
      m_rr = 0; m_cnt = 0; m_rdata = 0;
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] mask;
         int           delay;
         logic [15:0]  dout;
         bit           to;
         mask  = N'($urandom_range(1, (1 << N) - 1));
         rd_v  = N'($urandom);
         addr_v = (N*16)'({$urandom, $urandom});
         wdata_v = (N*16)'({$urandom, $urandom});
         delay = $urandom_range(0, 20);
         dout  = 16'($urandom);
         g = -1;
         for (int k = N - 1; k >= 0; k--)
            if (mask[(m_rr + k) % N]) g = (m_rr + k) % N;
         run_access(mask, rd_v, addr_v, wdata_v, delay, dout, g, lat, rv, err, rdata, cnt);
         to = (delay >= TO);
         if (!to && rd_v[g]) m_rdata = dout;
         if (to && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         check("rand_latency", 64'(lat), 64'(to ? TO + 1 : delay + 2));
         check("rand_rsp_valid", 64'(rv), 64'(N'(1) << g));
         check("rand_rsp", {err, rdata, cnt}, {to, m_rdata, m_cnt});
         m_rr = (g + 1) % N;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
